// File: rtl/decode_stage_pipe.sv
// RV32I/RV32E decode stage: IF/ID and ID/EX registers, register file, immediates, load-use stall.
// Optional macro WB_BYPASS_EN: same-cycle writeback write-through instead of a one-cycle stall.
module decode_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int PC_WIDTH  = 32,
  localparam int RA       = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [31:0]         if_instr,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                id_ready,
  input  logic                ex_stall,
  input  logic                flush,
  input  logic                wb_we,
  input  logic [RA-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                ex_valid,
  output logic [PC_WIDTH-1:0] ex_pc,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [RA-1:0]       ex_rs1,
  output logic [RA-1:0]       ex_rs2,
  output logic [RA-1:0]       ex_rd,
  output logic [XLEN-1:0]     ex_imm,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic                ex_funct7b5
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic                r_id_valid;
  logic [31:0]         r_id_instr;
  logic [PC_WIDTH-1:0] r_id_pc;

  logic                r_ex_valid;
  logic [PC_WIDTH-1:0] r_ex_pc;
  logic [XLEN-1:0]     r_ex_rs1_data;
  logic [XLEN-1:0]     r_ex_rs2_data;
  logic [RA-1:0]       r_ex_rs1;
  logic [RA-1:0]       r_ex_rs2;
  logic [RA-1:0]       r_ex_rd;
  logic [XLEN-1:0]     r_ex_imm;
  logic [6:0]          r_ex_opcode;
  logic [2:0]          r_ex_funct3;
  logic                r_ex_funct7b5;

  logic [XLEN-1:0]     r_rf [REG_COUNT];

  logic [6:0]          w_opcode;
  logic [RA-1:0]       w_rs1;
  logic [RA-1:0]       w_rs2;
  logic [RA-1:0]       w_rd;
  logic [XLEN-1:0]     w_imm;
  logic [XLEN-1:0]     w_rs1_data;
  logic [XLEN-1:0]     w_rs2_data;
  logic                w_use_rs1;
  logic                w_use_rs2;
  logic                w_hz;
  logic                w_wb_hz;
  logic                w_id_ready;

  assign w_opcode = r_id_instr[6:0];
  assign w_rs1    = r_id_instr[15 +: RA];
  assign w_rs2    = r_id_instr[20 +: RA];
  assign w_rd     = r_id_instr[7 +: RA];

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        w_imm = {{(XLEN-12){r_id_instr[31]}}, r_id_instr[31:20]};
      OPC_STORE:
        w_imm = {{(XLEN-12){r_id_instr[31]}}, r_id_instr[31:25], r_id_instr[11:7]};
      OPC_BRANCH:
        w_imm = {{(XLEN-12){r_id_instr[31]}}, r_id_instr[7], r_id_instr[30:25],
                 r_id_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm = {{(XLEN-31){r_id_instr[31]}}, r_id_instr[30:12], 12'b0};
      OPC_JAL:
        w_imm = {{(XLEN-20){r_id_instr[31]}}, r_id_instr[19:12], r_id_instr[20],
                 r_id_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign w_use_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) || (w_opcode == OPC_JAL));
  assign w_use_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) || (w_opcode == OPC_BRANCH);

  // Only a load in EX is too late to forward; everything else is resolved by execute.
  assign w_hz = r_id_valid && r_ex_valid && (r_ex_opcode == OPC_LOAD) && (r_ex_rd != '0) &&
                ((w_use_rs1 && (w_rs1 == r_ex_rd)) || (w_use_rs2 && (w_rs2 == r_ex_rd)));

`ifdef WB_BYPASS_EN
  assign w_rs1_data = (w_rs1 == '0) ? '0 : ((wb_we && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1]);
  assign w_rs2_data = (w_rs2 == '0) ? '0 : ((wb_we && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2]);
  assign w_wb_hz    = 1'b0;
`else
  assign w_rs1_data = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
  // Hold decode one cycle so the operand is read after the write has landed.
  assign w_wb_hz    = r_id_valid && wb_we && (wb_rd != '0) &&
                      ((w_use_rs1 && (w_rs1 == wb_rd)) || (w_use_rs2 && (w_rs2 == wb_rd)));
`endif

  assign w_id_ready = !ex_stall && !w_hz && !w_wb_hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < REG_COUNT; k++) begin
        r_rf[k] <= '0;
      end
    end else if (wb_we && (wb_rd != '0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (w_id_ready) begin
      r_id_valid <= if_valid;
      r_id_instr <= if_instr;
      r_id_pc    <= if_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_imm      <= '0;
      r_ex_opcode   <= '0;
      r_ex_funct3   <= '0;
      r_ex_funct7b5 <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (!ex_stall) begin
      if (w_hz || w_wb_hz) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid    <= r_id_valid;
        r_ex_pc       <= r_id_pc;
        r_ex_rs1_data <= w_rs1_data;
        r_ex_rs2_data <= w_rs2_data;
        r_ex_rs1      <= w_rs1;
        r_ex_rs2      <= w_rs2;
        r_ex_rd       <= w_rd;
        r_ex_imm      <= w_imm;
        r_ex_opcode   <= w_opcode;
        r_ex_funct3   <= r_id_instr[14:12];
        r_ex_funct7b5 <= r_id_instr[30];
      end
    end
  end

  assign id_ready    = w_id_ready;
  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_rs1_data = r_ex_rs1_data;
  assign ex_rs2_data = r_ex_rs2_data;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign ex_rd       = r_ex_rd;
  assign ex_imm      = r_ex_imm;
  assign ex_opcode   = r_ex_opcode;
  assign ex_funct3   = r_ex_funct3;
  assign ex_funct7b5 = r_ex_funct7b5;

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised RV32I/RV32E decode stage for the pipelined core. It owns the IF/ID and ID/EX pipeline registers, the architectural register file and immediate generation. It also contains load-use hazard detection and stall/flush handling. It sits between fetch and execute, and its ID/EX outputs are registered.

Parameters:
XLEN, 32, datapath and register width
REG_COUNT, 32, number of architectural registers (32 = RV32I, 16 = RV32E); address width RA = $clog2(REG_COUNT)
PC_WIDTH, 32, program counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  32  fetched instruction
if_pc  in  PC_WIDTH  PC of if_instr
id_ready  out  1  decode accepts if_* this cycle (0 = stall fetch)
ex_stall  in  1  execute cannot accept; hold ID/EX
flush  in  1  taken branch/jump in execute; kill IF/ID and ID/EX
wb_we  in  1  writeback enable
wb_rd  in  RA  writeback destination
wb_data  in  XLEN  writeback data
ex_valid  out  1  ID/EX holds a live instruction
ex_pc  out  PC_WIDTH  PC
ex_rs1_data, ex_rs2_data  out  XLEN  operand values
ex_rs1, ex_rs2, ex_rd  out  RA  register indices (for forwarding)
ex_imm  out  XLEN  sign-extended immediate
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7b5  out  1  instr[30]

Behaviour:
- Reset (async): id_valid, ex_valid = 0. All ex_* data outputs = 0. All registers in the file = 0. id_ready = 1 after reset.
- IF/ID capture: when id_ready=1, the block loads id_instr/id_pc/id_valid <= if_instr/if_pc/if_valid. When id_ready=0, it holds.
- Register file reads use instr[19:15] and [24:20], truncated to RA bits. Index 0 always reads 0, and writes to x0 are ignored. Writes commit on the clk rising edge when wb_we=1.
- Immediate generation selects the format by opcode. I (LOAD, OP-IMM, JALR), S, B, U (LUI, AUIPC) and J formats are all sign-extended to XLEN. All other opcodes produce 0.
- Operand usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
- Load-use hazard (hz) = id_valid & ex_valid & ex_opcode==LOAD(0000011) & ex_rd!=0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
- id_ready = !ex_stall & !hz & !wb_hz (for wb_hz, see Optional Feature). This is combinational.
- ID/EX update priority, highest first:
  - flush: ex_valid<=0 and id_valid<=0 next cycle. Flush overrides stalls and if_valid.
  - ex_stall: ID/EX holds.
  - hz or wb_hz: ID/EX loads a bubble (ex_valid<=0, other fields don't-care), and IF/ID holds.
  - otherwise: ID/EX loads the decoded fields, with ex_valid<=id_valid.
- Latency: an instruction accepted at edge N appears on ex_* after edge N+1 when there are no stalls.
- A load-use hazard costs exactly one bubble.
- Reset asserted mid-stall clears everything. No partial state survives.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: same-cycle write-through. If wb_we & wb_rd!=0 & wb_rd matches a read index, the read returns wb_data. wb_hz = 0.
- Undefined: reads return the pre-write value. wb_hz = id_valid & wb_we & wb_rd!=0 & (use_rs1 & rs1==wb_rd | use_rs2 & rs2==wb_rd). This stalls one cycle so the read occurs after the write commits.

Test Plan:
- Reset then idle: ex_valid=0 and id_ready=1. A read of x0 with wb_we=1, wb_rd=0, wb_data=0xFFFFFFFF gives ex_rs1_data=0.
- Stream "addi x1,x0,5" (0x00500093): two cycles later ex_valid=1, ex_rd=1, ex_imm=5, ex_opcode=0x13.
- "lw x2,0(x1)" followed by "add x3,x2,x1":
  - one cycle with id_ready=0 and ex_valid=0 (bubble);
  - the add then appears on the next cycle with ex_rs1=2.
- "beq" offset -4 (0xFE000EE3): ex_imm=0xFFFFFFFC.
- flush=1 while ex_stall=1 and if_valid=1: next cycle ex_valid=0, and the instruction held in IF/ID is discarded.
- wb_we=1, wb_rd=5, wb_data=0x1234, decoding an add reading x5:
  - with WB_BYPASS_EN: ex_rs1_data=0x1234 and no stall;
  - without it: one cycle with id_ready=0, then ex_rs1_data=0x1234.
